// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit add/subtract unit.
// Optional macro ALU_SHARE_ARBITER_SAT_EN selects saturating instead of wrapping arithmetic.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's operands
// EXEC  | computes the result from the latched operands
// RESP  | holds the result on the response channel until rsp_ready
module alu_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             last_gnt, last_gnt_nxt;
  logic             lat_op, lat_op_nxt;
  logic [WIDTH-1:0] lat_a, lat_a_nxt;
  logic [WIDTH-1:0] lat_b, lat_b_nxt;

  logic [1:0]       gnt_nxt;
  logic             busy_nxt;
  logic             rsp_valid_nxt;
  logic             rsp_id_nxt;
  logic [WIDTH-1:0] rsp_data_nxt;
  logic [CNT_W-1:0] done_cnt_nxt;

  logic             win;
  logic [WIDTH-1:0] alu_res;

  // A lone request wins outright; on a tie the requester not granted last time wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_gnt;
      default: win = 1'b0;
    endcase
  end

`ifdef ALU_SHARE_ARBITER_SAT_EN
  logic [WIDTH:0] sum_ext, diff_ext;

  always_comb begin
    sum_ext  = {1'b0, lat_a} + {1'b0, lat_b};
    diff_ext = {1'b0, lat_a} - {1'b0, lat_b};
    if (!lat_op) begin
      alu_res = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
    end else begin
      alu_res = diff_ext[WIDTH] ? {WIDTH{1'b0}} : diff_ext[WIDTH-1:0];
    end
  end
`else
  always_comb begin
    alu_res = lat_op ? (lat_a - lat_b) : (lat_a + lat_b);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; nothing leaves the block combinationally.
  always_comb begin
    gnt_nxt       = 2'b00;
    busy_nxt      = (state_nxt != IDLE);
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_data_nxt  = rsp_data;
    done_cnt_nxt  = done_cnt;
    last_gnt_nxt  = last_gnt;
    lat_op_nxt    = lat_op;
    lat_a_nxt     = lat_a;
    lat_b_nxt     = lat_b;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_nxt      = win ? 2'b10 : 2'b01;
          last_gnt_nxt = win;
          lat_op_nxt   = win ? op[1] : op[0];
          lat_a_nxt    = win ? a1 : a0;
          lat_b_nxt    = win ? b1 : b0;
        end
      end
      EXEC: begin
        rsp_valid_nxt = 1'b1;
        rsp_id_nxt    = last_gnt;
        rsp_data_nxt  = alu_res;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          done_cnt_nxt  = done_cnt + CNT_W'(1);
        end
      end
      default: begin
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= 2'b00;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      done_cnt  <= '0;
      last_gnt  <= 1'b1;
      lat_op    <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
    end else begin
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_data  <= rsp_data_nxt;
      done_cnt  <= done_cnt_nxt;
      last_gnt  <= last_gnt_nxt;
      lat_op    <= lat_op_nxt;
      lat_a     <= lat_a_nxt;
      lat_b     <= lat_b_nxt;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter using a response scoreboard queue.
module tb_alu_share_arbiter;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic             rsp_ready = 1'b1;
  logic [1:0]       gnt;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic [CNT_W-1:0] done_cnt;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_done = 0;
  logic [WIDTH:0] sb[$];

  function automatic logic [WIDTH-1:0] model(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int r;
    int lim;
    lim = 1 << WIDTH;
    r = o ? (int'(a) - int'(b)) : (int'(a) + int'(b));
`ifdef ALU_SHARE_ARBITER_SAT_EN
    if (r >= lim) r = lim - 1;
    if (r < 0) r = 0;
`else
    if (r >= lim) r = r - lim;
    if (r < 0) r = r + lim;
`endif
    return r[WIDTH-1:0];
  endfunction

  // Called at a falling edge while the DUT is idle.
  task automatic drive_req(input int id, input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic idb;
    idb = id[0];
    if (idb == 1'b0) begin
      op[0] = o; a0 = a; b0 = b;
    end else begin
      op[1] = o; a1 = a; b1 = b;
    end
    req[idb] = 1'b1;
    sb.push_back({idb, model(o, a, b)});
  endtask

  task automatic wait_gnt(output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g = gnt;
        ok = 1'b1;
        req = 2'b00;
        break;
      end
    end
    req = 2'b00;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 2'b00;
    rsp_ready = 1'b1;
    sb.delete();
    exp_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({gnt, busy, rsp_valid, rsp_id, rsp_data, done_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b valid=%b id=%b data=%h cnt=%0d, need all zero",
               gnt, busy, rsp_valid, rsp_id, rsp_data, done_cnt);
    end
    apply_reset();
  endtask

  task automatic test_single_add();
    logic [1:0] g;
    bit ok;
    logic [WIDTH:0] e;
    rsp_ready = 1'b1;
    drive_req(0, 1'b0, 4'b0110, 4'b0010);
    wait_gnt(g, ok);
    n_cmp++;
    if (!ok || g !== 2'b01 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL add_gnt: got gnt=%b busy=%b ok=%0d, need gnt=01 busy=1", g, busy, ok);
    end
    wait_rsp(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || rsp_id !== 1'b0 || rsp_data !== 4'b1000 || e !== {1'b0, rsp_data}) begin
      n_err++;
      $display("FAIL add_rsp: got ok=%0d id=%b data=%b, need id=0 data=1000", ok, rsp_id, rsp_data);
    end
    @(negedge clk);
    exp_done++;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== exp_done[CNT_W-1:0]) begin
      n_err++;
      $display("FAIL add_done: got valid=%b busy=%b cnt=%0d, need valid=0 busy=0 cnt=%0d",
               rsp_valid, busy, done_cnt, exp_done);
    end
  endtask

  task automatic test_arith();
    logic [1:0] g;
    bit ok;
    logic [WIDTH:0] e;
    int ids[5]  = '{1, 0, 0, 1, 1};
    logic ops[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] as[5] = '{4'b0010, 4'b1111, 4'b1001, 4'b0111, 4'b0101};
    logic [WIDTH-1:0] bs[5] = '{4'b0110, 4'b0011, 4'b0100, 4'b1000, 4'b0101};
    for (int k = 0; k < 5; k++) begin
      drive_req(ids[k], ops[k], as[k], bs[k]);
      wait_gnt(g, ok);
      n_cmp++;
      if (!ok || g !== (ids[k] == 1 ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL arith_gnt[%0d]: got %b ok=%0d, need requester %0d", k, g, ok, ids[k]);
      end
      wait_rsp(ok);
      if (sb.size() == 0) begin
        e = '0;
        n_err++;
        $display("FAIL arith_sb[%0d]: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
      end
      n_cmp++;
      if (!ok || {rsp_id, rsp_data} !== e) begin
        n_err++;
        $display("FAIL arith_rsp[%0d]: got id=%b data=%b, need id=%b data=%b", k, rsp_id, rsp_data, e[WIDTH], e[WIDTH-1:0]);
      end
      @(negedge clk);
      exp_done++;
    end
    n_cmp++;
    if (done_cnt !== exp_done[CNT_W-1:0]) begin
      n_err++;
      $display("FAIL arith_cnt: got %0d, need %0d", done_cnt, exp_done);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    bit ok;
    logic [WIDTH:0] e;
    rsp_ready = 1'b0;
    drive_req(1, 1'b0, 4'b1001, 4'b0011);
    wait_gnt(g, ok);
    wait_rsp(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {rsp_id, rsp_data} !== e) begin
      n_err++;
      $display("FAIL bp_rsp: got ok=%0d id=%b data=%b, need id=%b data=%b", ok, rsp_id, rsp_data, e[WIDTH], e[WIDTH-1:0]);
    end
    req = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e || busy !== 1'b1 || gnt !== 2'b00) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b id=%b data=%b busy=%b gnt=%b, need 1/%b/%b/1/00",
                 c, rsp_valid, rsp_id, rsp_data, busy, gnt, e[WIDTH], e[WIDTH-1:0]);
      end
    end
    rsp_ready = 1'b1;
    req = 2'b00;
    @(negedge clk);
    exp_done++;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== exp_done[CNT_W-1:0] || {rsp_id, rsp_data} !== e) begin
      n_err++;
      $display("FAIL bp_release: got valid=%b busy=%b cnt=%0d id=%b data=%b, need 0/0/%0d hold",
               rsp_valid, busy, done_cnt, rsp_id, rsp_data, exp_done);
    end
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_idle: got gnt=%b busy=%b, need 00/0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    bit ok;
    logic [WIDTH:0] e;
    rsp_ready = 1'b0;
    drive_req(0, 1'b1, 4'b1100, 4'b0001);
    wait_gnt(g, ok);
    wait_rsp(ok);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, busy, rsp_valid, rsp_id, rsp_data, done_cnt} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got gnt=%b busy=%b valid=%b id=%b data=%h cnt=%0d, need all zero",
               gnt, busy, rsp_valid, rsp_id, rsp_data, done_cnt);
    end
    sb.delete();
    exp_done = 0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || done_cnt !== '0) begin
      n_err++;
      $display("FAIL midrst_norsp: got valid=%b cnt=%0d, need 0/0", rsp_valid, done_cnt);
    end
    a0 = 4'b0011; b0 = 4'b0100; a1 = 4'b1000; b1 = 4'b0001; op = 2'b00;
    req = 2'b11;
    sb.push_back({1'b0, model(1'b0, 4'b0011, 4'b0100)});
    wait_gnt(g, ok);
    n_cmp++;
    if (!ok || g !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_gnt: got %b ok=%0d, need 01", g, ok);
    end
    wait_rsp(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {rsp_id, rsp_data} !== e) begin
      n_err++;
      $display("FAIL midrst_rsp: got id=%b data=%b, need id=%b data=%b", rsp_id, rsp_data, e[WIDTH], e[WIDTH-1:0]);
    end
    @(negedge clk);
    exp_done++;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    logic [WIDTH:0] e;
    int n_g;
    int n_r;
    apply_reset();
    a0 = 4'b0101; b0 = 4'b0110; a1 = 4'b1101; b1 = 4'b0100; op = 2'b10;
    exp_g = 2'b01;
    n_g = 0;
    n_r = 0;
    req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        n_cmp++;
        if (gnt !== exp_g) begin
          n_err++;
          $display("FAIL fair_gnt[%0d]: got %b, need %b", n_g, gnt, exp_g);
        end
        if (exp_g == 2'b01) sb.push_back({1'b0, model(op[0], a0, b0)});
        else                sb.push_back({1'b1, model(op[1], a1, b1)});
        exp_g = ~exp_g;
        n_g++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          e = '0;
          n_err++;
          $display("FAIL fair_sb[%0d]: scoreboard empty", n_r);
        end else begin
          e = sb.pop_front();
        end
        n_cmp++;
        if ({rsp_id, rsp_data} !== e) begin
          n_err++;
          $display("FAIL fair_rsp[%0d]: got id=%b data=%b, need id=%b data=%b", n_r, rsp_id, rsp_data, e[WIDTH], e[WIDTH-1:0]);
        end
        exp_done++;
        n_r++;
      end
    end
    req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (n_g != 4 || n_r != 4 || done_cnt !== exp_done[CNT_W-1:0]) begin
      n_err++;
      $display("FAIL fair_count: got grants=%0d rsps=%0d cnt=%0d, need 4/4/%0d", n_g, n_r, done_cnt, exp_done);
    end
  endtask

  task automatic test_done_wrap();
    logic [1:0] g;
    bit ok;
    logic [WIDTH:0] e;
    int id;
    rsp_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      id = int'($urandom_range(0, 1));
      drive_req(id, 1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom));
      wait_gnt(g, ok);
      n_cmp++;
      if (!ok || g !== (id == 1 ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL wrap_gnt[%0d]: got %b ok=%0d, need requester %0d", k, g, ok, id);
      end
      wait_rsp(ok);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_cmp++;
      if (!ok || {rsp_id, rsp_data} !== e) begin
        n_err++;
        $display("FAIL wrap_rsp[%0d]: got id=%b data=%b, need id=%b data=%b", k, rsp_id, rsp_data, e[WIDTH], e[WIDTH-1:0]);
      end
      @(negedge clk);
      exp_done++;
      n_cmp++;
      if (done_cnt !== exp_done[CNT_W-1:0]) begin
        n_err++;
        $display("FAIL wrap_cnt[%0d]: got %0d, need %0d", k, done_cnt, exp_done % (1 << CNT_W));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_fairness();
    test_done_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
